// File: rtl/key_pkg.sv
// Shared constants and state encoding for the 4-channel key debouncer.
package key_pkg;

    localparam int unsigned KEY_NUM = 4;

    localparam int unsigned CNT_W_DEF    = 20;
    localparam logic [19:0] CNT_MAX_DEF  = 20'd999_999;
    localparam int unsigned LONG_W_DEF   = 26;
    localparam logic [25:0] LONG_MAX_DEF = 26'd49_999_999;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_FLT = 2'd1,
        DOWN      = 2'd2,
        REL_FLT   = 2'd3
    } key_fsm_e;

endpackage

// File: rtl/key_filter_ch.sv
// One debounce channel: 2-FF synchroniser, stability filter FSM, registered strobes.
// Long-press strobe is built only when KEY_LONG_PRESS_EN is defined.
module key_filter_ch
    import key_pkg::*;
#(
    parameter int unsigned       CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_MAX_DEF,
    parameter int unsigned       LONG_W   = LONG_W_DEF,
    parameter logic [LONG_W-1:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    logic sync_1, key_sync;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_1   <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            sync_1   <= key_in;
            key_sync <= sync_1;
        end
    end

    key_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, key_state_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_state   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_state   <= key_state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!key_sync) begin
                    state_d = PRESS_FLT;
                    cnt_d   = '0;
                end
            end
            PRESS_FLT: begin
                if (key_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                if (key_sync) begin
                    state_d = REL_FLT;
                    cnt_d   = '0;
                end
            end
            REL_FLT: begin
                if (!key_sync) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        key_state_d = (state_d == DOWN) || (state_d == REL_FLT);
    end

`ifdef KEY_LONG_PRESS_EN
    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_done_q, long_done_d, long_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            key_long    <= long_d;
        end
    end

    // Held in REL_FLT so a release bounce back to DOWN resumes without re-firing.
    always_comb begin
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        unique case (state_q)
            IDLE, PRESS_FLT: begin
                long_cnt_d  = '0;
                long_done_d = 1'b0;
            end
            DOWN: begin
                if (!long_done_q) begin
                    if (long_cnt_q == LONG_MAX) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        long_cnt_d = long_cnt_q + LONG_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end
`else
    logic long_unused;
    assign long_unused = ^LONG_MAX;
    assign key_long    = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_4ch.sv
// Four independent debounced push-button channels (active-low raw inputs).
// Define KEY_LONG_PRESS_EN to enable the key_long strobes.
module key_debounce_4ch
    import key_pkg::*;
#(
    parameter int unsigned       CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_MAX_DEF,
    parameter int unsigned       LONG_W   = LONG_W_DEF,
    parameter logic [LONG_W-1:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_filter_ch #(
            .CNT_W    (CNT_W),
            .CNT_MAX  (CNT_MAX),
            .LONG_W   (LONG_W),
            .LONG_MAX (LONG_MAX)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .key_in      (key_in[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule
